// File: rtl/cayde_regfile_sb.sv
// Register file with XLEN-wide, NREGS-deep storage, 2 read ports and 1 write port.
// It has a write-to-read bypass, a per-register busy scoreboard and a post-reset init sweep.
// Defining CAYDE_RF_HAZARD_CNT_EN adds hazard_cnt_out, a saturating count of stalled reservations.
module cayde_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr_in1,
  input  logic [AW-1:0]   raddr_in2,
  output logic [XLEN-1:0] rdata_out1,
  output logic [XLEN-1:0] rdata_out2,
  output logic            rbusy_out1,
  output logic            rbusy_out2,
  input  logic            rsv_valid_in,
  input  logic [AW-1:0]   rsv_addr_in,
  output logic            rsv_ready_out,
  input  logic            wen_in,
  input  logic [AW-1:0]   waddr_in,
  input  logic [XLEN-1:0] wdata_in,
  output logic            ready_out
`ifdef CAYDE_RF_HAZARD_CNT_EN
  ,
  output logic [31:0]     hazard_cnt_out
`endif
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   sweepIdx_q, sweepIdx_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic running;
  logic writeLive;
  logic rsvAccept;

  // Outputs are forced idle while rst is high, even before the reset edge.
  assign running   = (state_q == RUN) && !rst;
  assign writeLive = running && wen_in && (waddr_in != '0);
  assign rsvAccept = rsv_valid_in && rsv_ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      sweepIdx_q <= '0;
    end else begin
      state_q    <= state_d;
      sweepIdx_q <= sweepIdx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweepIdx_d = sweepIdx_q;
    if (state_q == INIT) begin
      if (sweepIdx_q == LastIdx) begin
        state_d    = RUN;
        sweepIdx_d = '0;
      end else begin
        sweepIdx_d = sweepIdx_q + 1'b1;
      end
    end
  end

  always_comb begin
    ready_out     = running;
    rsv_ready_out = running && (!busy_q[rsv_addr_in] || (wen_in && waddr_in == rsv_addr_in));
    rdata_out1    = '0;
    rdata_out2    = '0;
    rbusy_out1    = 1'b0;
    rbusy_out2    = 1'b0;
    if (running) begin
      if (raddr_in1 != '0) begin
        rdata_out1 = (wen_in && waddr_in == raddr_in1) ? wdata_in : regs_q[raddr_in1];
      end
      if (raddr_in2 != '0) begin
        rdata_out2 = (wen_in && waddr_in == raddr_in2) ? wdata_in : regs_q[raddr_in2];
      end
      rbusy_out1 = busy_q[raddr_in1] && !(wen_in && waddr_in == raddr_in1);
      rbusy_out2 = busy_q[raddr_in2] && !(wen_in && waddr_in == raddr_in2);
    end
  end

  // The write clears busy first so that a same-address reservation in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (writeLive) begin
      busy_d[waddr_in] = 1'b0;
    end
    if (running && rsvAccept && rsv_addr_in != '0) begin
      busy_d[rsv_addr_in] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Storage has no reset and behaves like a RAM; the sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        regs_q[sweepIdx_q] <= '0;
      end else if (writeLive) begin
        regs_q[waddr_in] <= wdata_in;
      end
    end
  end

`ifdef CAYDE_RF_HAZARD_CNT_EN
  logic [31:0] hazardCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hazardCnt_q <= '0;
    end else if (running && rsv_valid_in && !rsv_ready_out && hazardCnt_q != 32'hFFFF_FFFF) begin
      hazardCnt_q <= hazardCnt_q + 32'd1;
    end
  end

  assign hazard_cnt_out = hazardCnt_q;
`endif

endmodule

// File: tb/tb_cayde_regfile_sb.sv
// Directed testbench for cayde_regfile_sb.
// It covers a default 32x32 instance and a 64-bit x 16-entry instance.
module tb_cayde_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  raddr1, raddr2, rsvAddr, waddr;
  logic [31:0] rdata1, rdata2, wdata;
  logic        rbusy1, rbusy2, rsvValid, rsvReady, wen, ready;

  logic [3:0]  pRaddr1, pRaddr2, pRsvAddr, pWaddr;
  logic [63:0] pRdata1, pRdata2, pWdata;
  logic        pRbusy1, pRbusy2, pRsvValid, pRsvReady, pWen, pReady;

`ifdef CAYDE_RF_HAZARD_CNT_EN
  logic [31:0] hazardCnt, pHazardCnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  cayde_regfile_sb dut (
    .clk(clk), .rst(rst),
    .raddr_in1(raddr1), .raddr_in2(raddr2),
    .rdata_out1(rdata1), .rdata_out2(rdata2),
    .rbusy_out1(rbusy1), .rbusy_out2(rbusy2),
    .rsv_valid_in(rsvValid), .rsv_addr_in(rsvAddr), .rsv_ready_out(rsvReady),
    .wen_in(wen), .waddr_in(waddr), .wdata_in(wdata),
    .ready_out(ready)
`ifdef CAYDE_RF_HAZARD_CNT_EN
    , .hazard_cnt_out(hazardCnt)
`endif
  );

  cayde_regfile_sb #(.XLEN(64), .NREGS(16), .AW(4)) dutP (
    .clk(clk), .rst(rst),
    .raddr_in1(pRaddr1), .raddr_in2(pRaddr2),
    .rdata_out1(pRdata1), .rdata_out2(pRdata2),
    .rbusy_out1(pRbusy1), .rbusy_out2(pRbusy2),
    .rsv_valid_in(pRsvValid), .rsv_addr_in(pRsvAddr), .rsv_ready_out(pRsvReady),
    .wen_in(pWen), .waddr_in(pWaddr), .wdata_in(pWdata),
    .ready_out(pReady)
`ifdef CAYDE_RF_HAZARD_CNT_EN
    , .hazard_cnt_out(pHazardCnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drives the default instance's inputs, then lets the combinational outputs settle.
  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic rv, input logic [4:0] ra,
                               input logic [4:0] r1, input logic [4:0] r2);
    wen = w; waddr = wa; wdata = wd;
    rsvValid = rv; rsvAddr = ra;
    raddr1 = r1; raddr2 = r2;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pRaddr1 = '0; pRaddr2 = '0; pRsvAddr = '0; pRsvValid = 1'b0;
    pWen = 1'b0; pWaddr = '0; pWdata = '0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd5, 5'd0);
    checkOutput("rst_ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_rsv_ready", {63'd0, rsvReady}, 64'd0);
    checkOutput("rst_rdata1", {32'd0, rdata1}, 64'd0);
    repeat (3) stepClock();
    rst = 1'b0;

    // Sweep: the default instance becomes ready after 32 edges and the small one after 16.
    for (int i = 1; i <= 32; i++) begin
      stepClock();
      if (i == 10) begin
        checkOutput("init_rsv_ready", {63'd0, rsvReady}, 64'd0);
        checkOutput("init_rdata1", {32'd0, rdata1}, 64'd0);
      end
      if (i == 15) checkOutput("p_ready_e15", {63'd0, pReady}, 64'd0);
      if (i == 16) checkOutput("p_ready_e16", {63'd0, pReady}, 64'd1);
      if (i == 20) rsvValid = 1'b0;
      if (i == 31) checkOutput("ready_e31", {63'd0, ready}, 64'd0);
    end
    checkOutput("ready_e32", {63'd0, ready}, 64'd1);

    // Wide instance write and readback.
    pWen = 1'b1; pWaddr = 4'd15; pWdata = 64'hFFFF_0000_1234_5678; pRaddr1 = 4'd15;
    #1;
    checkOutput("p_x15_bypass", pRdata1, 64'hFFFF_0000_1234_5678);
    stepClock();
    pWen = 1'b0;
    #1;
    checkOutput("p_x15_stored", pRdata1, 64'hFFFF_0000_1234_5678);

    // Write x5, then write x0.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    checkOutput("x5_bypass", {32'd0, rdata1}, 64'hDEADBEEF);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    checkOutput("x5_stored", {32'd0, rdata1}, 64'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_bypass", {32'd0, rdata1}, 64'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_stored", {32'd0, rdata1}, 64'd0);

    // Scoreboard on x7.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    checkOutput("x7_rsv_ready", {63'd0, rsvReady}, 64'd1);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    checkOutput("x7_busy", {63'd0, rbusy2}, 64'd1);
    checkOutput("x7_stall", {63'd0, rsvReady}, 64'd0);
    stepClock();
    applyStimulus(1'b1, 5'd7, 32'h55, 1'b0, 5'd7, 5'd0, 5'd7);
    checkOutput("x7_wb_busy", {63'd0, rbusy2}, 64'd0);
    checkOutput("x7_wb_data", {32'd0, rdata2}, 64'h55);
    checkOutput("x7_wb_rsv_ready", {63'd0, rsvReady}, 64'd1);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0, 5'd7);
    checkOutput("x7_after_busy", {63'd0, rbusy2}, 64'd0);
    checkOutput("x7_after_data", {32'd0, rdata2}, 64'h55);

    // Reserving x0 is accepted and has no effect.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_rsv_ready", {63'd0, rsvReady}, 64'd1);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_busy", {63'd0, rbusy1}, 64'd0);

    // Same-cycle write and reservation on x9; the reservation wins.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    stepClock();
    applyStimulus(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 5'd9, 5'd0);
    checkOutput("x9_wr_rsv_ready", {63'd0, rsvReady}, 64'd1);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    checkOutput("x9_data", {32'd0, rdata1}, 64'hA);
    checkOutput("x9_busy", {63'd0, rbusy1}, 64'd1);

    // Write x9 and reserve x10 in the same cycle.
    applyStimulus(1'b1, 5'd9, 32'hB, 1'b1, 5'd10, 5'd9, 5'd10);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd10);
    checkOutput("x9_freed", {63'd0, rbusy1}, 64'd0);
    checkOutput("x9_data_b", {32'd0, rdata1}, 64'hB);
    checkOutput("x10_busy", {63'd0, rbusy2}, 64'd1);
`ifdef CAYDE_RF_HAZARD_CNT_EN
    checkOutput("hazard_cnt", {32'd0, hazardCnt}, 64'd1);
`endif

    // Reset in the middle of operation.
    applyStimulus(1'b1, 5'd3, 32'h77, 1'b1, 5'd3, 5'd3, 5'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd3, 5'd0);
    checkOutput("x3_busy", {63'd0, rbusy1}, 64'd1);
    checkOutput("x3_data", {32'd0, rdata1}, 64'h77);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", {63'd0, ready}, 64'd0);
    checkOutput("midrst_busy", {63'd0, rbusy1}, 64'd0);
    checkOutput("midrst_rdata", {32'd0, rdata1}, 64'd0);
    checkOutput("midrst_rsv_ready", {63'd0, rsvReady}, 64'd0);
    stepClock();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      stepClock();
      if (i == 31) checkOutput("resweep_e31", {63'd0, ready}, 64'd0);
    end
    #1;
    checkOutput("resweep_ready", {63'd0, ready}, 64'd1);
    checkOutput("x3_cleared", {32'd0, rdata1}, 64'd0);
    checkOutput("x3_not_busy", {63'd0, rbusy1}, 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd5);
    checkOutput("x10_not_busy", {63'd0, rbusy1}, 64'd0);
    checkOutput("x5_cleared", {32'd0, rdata2}, 64'd0);
    checkOutput("p_x15_cleared", pRdata1, 64'd0);
`ifdef CAYDE_RF_HAZARD_CNT_EN
    checkOutput("hazard_cnt_cleared", {32'd0, hazardCnt}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cayde_regfile_sb.md
Name: cayde_regfile_sb

Overview:
- Parametrised successor to the cayde integer register file: XLEN-wide, NREGS-deep, 2 read ports, 1 write port.
- Adds a write-to-read bypass and a per-register busy scoreboard: the decode stage reserves a destination at issue, and writeback clears it.
- Adds a post-reset init-sweep state machine that clears storage one entry per cycle, modelling RAM-backed storage.
- Sits between decode/issue (read, reserve) and writeback (write).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- AW, 5, address width; must equal log2(NREGS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- raddr_in1  in  AW  read port 1 address.
- raddr_in2  in  AW  read port 2 address.
- rdata_out1  out  XLEN  read port 1 data, combinational.
- rdata_out2  out  XLEN  read port 2 data, combinational.
- rbusy_out1  out  1  register at raddr_in1 has a pending reservation.
- rbusy_out2  out  1  register at raddr_in2 has a pending reservation.
- rsv_valid_in  in  1  reservation request from issue.
- rsv_addr_in  in  AW  destination register to reserve.
- rsv_ready_out  out  1  reservation accepted this cycle when high with rsv_valid_in.
- wen_in  in  1  writeback enable.
- waddr_in  in  AW  writeback address.
- wdata_in  in  XLEN  writeback data.
- ready_out  out  1  init sweep complete; block operational.

Behaviour:
- Reset: one clock, reset synchronous and active-high on rst (fixed).
- While rst is high:
  - state is INIT, sweep index is 0, all busy bits are 0.
  - ready_out = 0, rsv_ready_out = 0, rdata_out1/2 = 0, rbusy_out1/2 = 0.
- INIT state:
  - Each cycle with rst low, clear reg[idx] to 0 and increment idx.
  - After clearing idx = NREGS-1, go to RUN. ready_out = 1 exactly NREGS cycles after the first edge with rst low.
  - In INIT: writes ignored, reservations refused, reads return 0.
- Reset mid-sweep or mid-RUN: return to INIT with idx = 0, clear all busy bits, and redo the full sweep.
- RUN state:
  - Writes and reservations are accepted and reads return live data.
  - Only rst leaves RUN.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are discarded.
  - Reservation of it is accepted (rsv_ready_out = 1) with no effect.
- Reads, combinational, per port:
  - If wen_in && waddr_in == raddr && raddr != 0, rdata = wdata_in (same-cycle bypass).
  - Otherwise rdata = reg[raddr].
- rbusy, per port: busy[raddr] && !(wen_in && waddr_in == raddr). A writeback in the same cycle masks busy.
- Write: when wen_in in RUN and waddr_in != 0, reg[waddr_in] <= wdata_in and busy[waddr_in] <= 0 at the edge.
  - Writing a non-busy register is legal.
- Reservation handshake:
  - rsv_ready_out = RUN && (!busy[rsv_addr_in] || (wen_in && waddr_in == rsv_addr_in)). No combinational dependence on rsv_valid_in.
  - Accept = rsv_valid_in && rsv_ready_out. On accept with rsv_addr_in != 0, busy[rsv_addr_in] <= 1.
  - Requester holds rsv_addr_in stable while valid and not ready.
- Simultaneous write and accepted reservation, same address: data written, busy ends 1 (the new reservation wins).
- Simultaneous write and reservation, different addresses: both take effect independently.
- Read latency 0 cycles. Write visible in storage 1 cycle after the edge; visible on reads in the same cycle via bypass.

Optional Feature:
- Macro: CAYDE_RF_HAZARD_CNT_EN.
- When defined:
  - Adds output port hazard_cnt_out, 32 bits.
  - Counts RUN cycles where rsv_valid_in && !rsv_ready_out.
  - Saturates at 0xFFFFFFFF; cleared by rst; holds in INIT.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Sweep timing: rst high 3 cycles, then low with NREGS=32 -> ready_out rises on the 32nd edge after rst falls; all reads return 0; rsv_ready_out = 0 throughout INIT.
- Write then read: RUN, write x5 = 0xDEADBEEF -> same cycle rdata_out1 (raddr 5) = 0xDEADBEEF via bypass; next cycle same value from storage; x0 write of 0x1234 -> reads 0.
- Scoreboard: reserve x7 -> next cycle rbusy_out2 (raddr 7) = 1, and rsv_ready_out = 0 for rsv_addr 7 (hazard_cnt_out increments by 1 per stalled cycle when enabled). Write x7 = 0x55 -> same cycle rbusy_out2 = 0 and rdata_out2 = 0x55; next cycle busy clear.
- Same-cycle write+reserve x9: busy[9] = 1 -> write x9 = 0xA with rsv_valid_in, rsv_addr 9 -> rsv_ready_out = 1; after edge x9 = 0xA, rbusy = 1.
- Reset mid-operation: x3 = 0x77 and busy, rst pulsed 1 cycle in RUN -> ready_out = 0, rbusy = 0 immediately; after sweep x3 reads 0.
- Parametrisation: XLEN=64, NREGS=16, AW=4 -> write x15 = 0xFFFF_0000_1234_5678 reads back exactly; ready_out after 16 cycles.
